// File: rtl/bist_result_dr.sv
// JTAG data register for the BIST result word: capture, LSB-first shift, update to a control word, error status.
// tdo, ctrl_word and ctrl_stb are registered one clk after the pulse. `define PARITY_EN_EN appends an odd-parity bit.
module bist_result_dr #(
  parameter int         W       = 16,
  parameter logic [7:0] HDR_ERR = 8'hFF,
  parameter logic [7:0] HDR_RST = 8'hF0,
  parameter int         CNT_W   = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [W-1:0]     bist_word,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  output logic             tdo,
  output logic [W-1:0]     ctrl_word,
  output logic             ctrl_stb,
  output logic             err_seen,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       err_code,
  output logic             short_shift,
  output logic             par_err
);

`ifdef PARITY_EN_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif
  localparam int               BC_W    = $clog2(LEN + 1);
  localparam logic [BC_W-1:0]  LEN_C   = BC_W'(LEN);
  localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, DONE} state_t;

  state_t          state, state_nxt;
  logic [LEN-1:0]  sr;
  logic [BC_W-1:0] bit_cnt;
  logic            do_shift, do_upd, upd_ok, upd_short;
  logic            hdr_err, shift_last, parity_ok;

  // A reset marker always wins if the two header codes are ever configured equal.
  assign hdr_err    = (bist_word[W-1:W-8] == HDR_ERR) && (HDR_ERR != HDR_RST);
  assign shift_last = (bit_cnt == LEN_C - BC_ONE);
  assign tdo        = sr[0];

`ifdef PARITY_EN_EN
  assign parity_ok = ^sr;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (capture_dr) begin
      state_nxt = LOADED;
    end else if (shift_dr) begin
      case (state)
        LOADED, SHIFTING: state_nxt = shift_last ? DONE : SHIFTING;
        default:          state_nxt = state;
      endcase
    end else if (update_dr && state != IDLE) begin
      state_nxt = IDLE;
    end
  end

  // Action decode: capture beats shift beats update.
  always_comb begin
    do_shift  = !capture_dr && shift_dr && (state != IDLE);
    do_upd    = !capture_dr && !shift_dr && update_dr;
    upd_ok    = do_upd && (state == DONE) && (bit_cnt == LEN_C) && parity_ok;
    upd_short = do_upd && ((state == LOADED) || (state == SHIFTING));
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (capture_dr) begin
`ifdef PARITY_EN_EN
      sr      <= {~^bist_word, bist_word};
`else
      sr      <= bist_word;
`endif
      bit_cnt <= '0;
    end else if (do_shift) begin
      sr <= {tdi, sr[LEN-1:1]};
      if (bit_cnt != LEN_C) bit_cnt <= bit_cnt + BC_ONE;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      err_seen    <= 1'b0;
      err_cnt     <= '0;
      err_code    <= '0;
      short_shift <= 1'b0;
    end else begin
      if (capture_dr && hdr_err) begin
        err_seen <= 1'b1;
        err_code <= bist_word[7:0];
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
      if (upd_short) short_shift <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ctrl_word <= '0;
      ctrl_stb  <= 1'b0;
    end else begin
      ctrl_stb <= upd_ok;
      if (upd_ok) ctrl_word <= sr[W-1:0];
    end
  end

`ifdef PARITY_EN_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) par_err <= 1'b0;
    else if (do_upd && (state == DONE) && (bit_cnt == LEN_C) && !parity_ok) par_err <= 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
